connect4_win_scanner: RTL and testbench

- Sequential win detector for the Connect 4 game FSM. After each accepted drop, it decides whether that piece completes a line of WIN_LEN.
- Reads the board one cell at a time through the board storage's registered read port. The game FSM's CHECK_1_WIN / CHECK_2_WIN states pulse start and wait for done.
- Early-exits on the first winning line found.

---
 rtl/connect4_win_scanner.sv | 196 +++++++++++++++++++
 tb/tb_connect4_win_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_win_scanner.sv
// rtl/connect4_win_scanner.sv - sequential Connect 4 win scan around the last dropped piece
// Define CONNECT4_DRAW_DETECT_EN to add the move counter with new_game/draw ports.
module connect4_win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] player,
  input  logic [2:0] mv_row,
  input  logic [2:0] mv_col,
  output logic       busy,
  output logic       rd_en,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
`ifdef CONNECT4_DRAW_DETECT_EN
  input  logic       new_game,
  output logic       draw,
`endif
  output logic       done,
  output logic       win
);

  localparam int CW  = $clog2(2 * WIN_LEN);
  localparam int CW1 = CW + 1;
  localparam int KW  = $clog2(WIN_LEN);
  localparam logic [3:0]    ROWS_U    = 4'(ROWS);
  localparam logic [3:0]    COLS_U    = 4'(COLS);
  localparam logic [CW:0]   WIN_C     = CW1'(WIN_LEN);
  localparam logic [KW-1:0] K_LAST    = KW'(WIN_LEN - 1);
  localparam logic [2:0]    SIDE_LAST = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic       ok;
    logic [2:0] row;
    logic [2:0] col;
  } cell_t;

  // Sides: 0 H+, 1 H-, 2 V-, 3 D1+, 4 D1-, 5 D2+, 6 D2-; signed 4-bit math catches off-board steps.
  function automatic cell_t side_cell(input logic [2:0] r0, input logic [2:0] c0,
                                      input logic [2:0] side_i, input logic [KW-1:0] k_i);
    logic signed [3:0] r, c, kk;
    cell_t o;
    r  = signed'({1'b0, r0});
    c  = signed'({1'b0, c0});
    kk = signed'(4'(k_i));
    case (side_i)
      3'd0:    c = c + kk;
      3'd1:    c = c - kk;
      3'd2:    r = r - kk;
      3'd3:    begin r = r + kk; c = c + kk; end
      3'd4:    begin r = r - kk; c = c - kk; end
      3'd5:    begin r = r + kk; c = c - kk; end
      default: begin r = r - kk; c = c + kk; end
    endcase
    o.ok  = !r[3] && !c[3] && (unsigned'(r) < ROWS_U) && (unsigned'(c) < COLS_U);
    o.row = r[2:0];
    o.col = c[2:0];
    return o;
  endfunction

  state_t        state;
  logic [1:0]    ply;
  logic [2:0]    row_q, col_q, side, side_nxt;
  logic [KW-1:0] k;
  logic [CW-1:0] count;
  logic [CW:0]   cnt_inc;
  logic          req_ok, hit, win_now, go_on, side_end, axis_start;
  cell_t         first_cell, cont_cell, next_cell;

`ifdef CONNECT4_DRAW_DETECT_EN
  localparam logic [5:0] MOVES_FULL = 6'(ROWS * COLS);
  logic [5:0] moves;
`endif

  assign req_ok     = (player == 2'b01 || player == 2'b10) &&
                      ({1'b0, mv_row} < ROWS_U) && ({1'b0, mv_col} < COLS_U);
  assign cnt_inc    = CW1'(count) + CW1'(1);
  assign hit        = (rd_data == ply);
  assign win_now    = hit && (cnt_inc >= WIN_C);
  assign go_on      = hit && (k != K_LAST);
  // An ISSUE cycle without a read strobe means the step fell off the board.
  assign side_end   = (state == ISSUE && !rd_en) || (state == WAIT && !win_now && !go_on);
  assign side_nxt   = side + 3'd1;
  assign axis_start = (side_nxt == 3'd2) || (side_nxt == 3'd3) || (side_nxt == 3'd5);
  assign first_cell = side_cell(mv_row, mv_col, 3'd0, KW'(1));
  assign cont_cell  = side_cell(row_q, col_q, side, k + KW'(1));
  assign next_cell  = side_cell(row_q, col_q, side_nxt, KW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ply    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      side   <= '0;
      k      <= '0;
      count  <= '0;
      busy   <= 1'b0;
      rd_en  <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
      done   <= 1'b0;
      win    <= 1'b0;
`ifdef CONNECT4_DRAW_DETECT_EN
      moves  <= '0;
      draw   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          ply   <= player;
          row_q <= mv_row;
          col_q <= mv_col;
          busy  <= 1'b1;
          win   <= 1'b0;
          if (req_ok) begin
            side  <= '0;
            k     <= KW'(1);
            count <= CW'(1);
            rd_en <= first_cell.ok;
            if (first_cell.ok) begin
              rd_row <= first_cell.row;
              rd_col <= first_cell.col;
            end
            state <= ISSUE;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        ISSUE: if (rd_en) begin
          rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (win_now) begin
            win   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (go_on) begin
            k     <= k + KW'(1);
            count <= cnt_inc[CW-1:0];
            rd_en <= cont_cell.ok;
            if (cont_cell.ok) begin
              rd_row <= cont_cell.row;
              rd_col <= cont_cell.col;
            end
            state <= ISSUE;
          end else if (hit) begin
            count <= cnt_inc[CW-1:0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (side_end) begin
        if (side == SIDE_LAST) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          side <= side_nxt;
          k    <= KW'(1);
          if (axis_start) count <= CW'(1);
          rd_en <= next_cell.ok;
          if (next_cell.ok) begin
            rd_row <= next_cell.row;
            rd_col <= next_cell.col;
          end
          state <= ISSUE;
        end
      end

`ifdef CONNECT4_DRAW_DETECT_EN
      if (side_end && side == SIDE_LAST) begin
        if (moves != 6'h3f) moves <= moves + 6'd1;
        if (moves + 6'd1 >= MOVES_FULL) draw <= 1'b1;
      end
      if (new_game) begin
        moves <= '0;
        draw  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_connect4_win_scanner.sv
// tb/tb_connect4_win_scanner.sv - directed self-checking bench for connect4_win_scanner
module tb_connect4_win_scanner;
  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int DR [7] = '{0, 0, -1, 1, -1, 1, -1};
  localparam int DC [7] = '{1, -1, 0, 1, -1, -1, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] player = 2'b00;
  logic [2:0] mv_row = 3'd0;
  logic [2:0] mv_col = 3'd0;
  logic       busy, rd_en, done, win;
  logic [2:0] rd_row, rd_col;
  logic [1:0] rd_data = 2'b11;
`ifdef CONNECT4_DRAW_DETECT_EN
  logic       new_game = 1'b0;
  logic       draw;
`endif

  int checks = 0;
  int fails = 0;
  int done_seen = 0;
  int exp_win = 0;
  int exp_draw = 0;
  bit draw_chk = 1'b0;
  int exp_reads[$];
  int got_reads[$];
  logic [1:0] board [ROWS][COLS];

  connect4_win_scanner #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .player(player), .mv_row(mv_row), .mv_col(mv_col),
    .busy(busy), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
`ifdef CONNECT4_DRAW_DETECT_EN
    .new_game(new_game), .draw(draw),
`endif
    .done(done), .win(win)
  );

  always #5 clk = ~clk;

  // Registered board read port; 11 outside the valid slot exposes mistimed sampling.
  always @(posedge clk)
    rd_data <= (rd_en && int'(rd_row) < ROWS && int'(rd_col) < COLS) ? board[rd_row][rd_col] : 2'b11;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) board[i][j] = 2'b00;
  endtask

  task automatic model_scan(input logic [1:0] p, input int r, input int c, output int w);
    int run, rr, cc;
    bit stop;
    exp_reads.delete();
    w = 0; run = 1; stop = 1'b0;
    if (!(p == 2'b01 || p == 2'b10) || r >= ROWS || c >= COLS) return;
    for (int s = 0; s < 7 && !stop; s++) begin
      if (s == 0 || s == 2 || s == 3 || s == 5) run = 1;
      for (int kk = 1; kk < WIN_LEN; kk++) begin
        rr = r + kk * DR[s];
        cc = c + kk * DC[s];
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) break;
        exp_reads.push_back(rr * 8 + cc);
        if (board[rr][cc] != p) break;
        run++;
        if (run >= WIN_LEN) begin w = 1; stop = 1'b1; break; end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && rd_en) got_reads.push_back(int'(rd_row) * 8 + int'(rd_col));
    if (rst && done) begin
      done_seen++;
      check("win", int'(win), exp_win);
      check("busy_at_done", int'(busy), 1);
      check("read_count", got_reads.size(), exp_reads.size());
      for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++)
        check("read_addr", got_reads[i], exp_reads[i]);
`ifdef CONNECT4_DRAW_DETECT_EN
      if (draw_chk) check("draw_at_done", int'(draw), exp_draw);
`endif
    end
  end

  task automatic run_scan(input logic [1:0] p, input int r, input int c, input int pin_win, input bit poke);
    int cyc;
    bit bad;
    model_scan(p, r, c, exp_win);
    if (pin_win >= 0) check("model_pin_win", exp_win, pin_win);
    bad = !(p == 2'b01 || p == 2'b10) || r >= ROWS || c >= COLS;
    got_reads.delete();
    done_seen = 0;
    @(negedge clk);
    start = 1'b1; player = p; mv_row = 3'(r); mv_col = 3'(c);
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    cyc = 1;
    while (done_seen == 0 && cyc < 60) begin
      if (poke && cyc == 3) begin start = 1'b1; player = 2'b11; end
      else start = 1'b0;
      @(negedge clk); #1;
      cyc++;
    end
    check("done_seen", done_seen, 1);
    if (bad) check("invalid_latency", cyc, 1);
    else check("latency_within_44", int'(cyc <= 44), 1);
    if (poke) begin start = 1'b1; player = 2'b11; end
    @(negedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("win_held", int'(win), exp_win);
  endtask

  initial begin
    clear_board();
    #2 rst = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_win", int'(win), 0);
    check("rst_rd_row", int'(rd_row), 0);
    check("rst_rd_col", int'(rd_col), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Empty board: (0,4), (0,2), (1,4), (1,2) read; V-, D1-, D2- fall off the bottom.
    run_scan(2'b01, 0, 3, 0, 1'b0);
    check("pin_t1_n", exp_reads.size(), 4);
    check("pin_t1_0", exp_reads[0], 4);
    check("pin_t1_2", exp_reads[2], 12);
    check("pin_t1_3", exp_reads[3], 10);

    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01; board[0][3] = 2'b01;
    run_scan(2'b01, 0, 3, 1, 1'b0);
    check("pin_t2_n", exp_reads.size(), 4);
    check("pin_t2_3", exp_reads[3], 0);
    run_scan(2'b10, 0, 3, 0, 1'b0);

    clear_board();
    board[2][5] = 2'b10; board[1][5] = 2'b10; board[0][5] = 2'b10; board[3][5] = 2'b10;
    run_scan(2'b10, 3, 5, 1, 1'b0);
    check("pin_t3_n", exp_reads.size(), 5);
    check("pin_t3_2", exp_reads[2], 21);

    clear_board();
    board[1][1] = 2'b01; board[3][3] = 2'b01; board[4][4] = 2'b01; board[2][2] = 2'b01;
    run_scan(2'b01, 2, 2, 1, 1'b0);
    check("pin_t4_n", exp_reads.size(), 7);
    board[4][4] = 2'b10;
    run_scan(2'b01, 2, 2, 0, 1'b0);
    check("pin_t5_n", exp_reads.size(), 9);

    // Split horizontal line, with stray starts mid-scan and on the done cycle.
    clear_board();
    board[0][1] = 2'b01; board[0][2] = 2'b01; board[0][4] = 2'b01; board[0][3] = 2'b01;
    run_scan(2'b01, 0, 3, 1, 1'b1);

    clear_board();
    board[5][3] = 2'b10; board[5][4] = 2'b10; board[5][5] = 2'b10; board[5][6] = 2'b10;
    run_scan(2'b10, 5, 6, 1, 1'b0);
    check("pin_t7_n", exp_reads.size(), 3);

    run_scan(2'b11, 0, 3, 0, 1'b0);
    run_scan(2'b00, 1, 1, 0, 1'b0);
    run_scan(2'b01, 0, 7, 0, 1'b0);
    run_scan(2'b10, 6, 0, 0, 1'b0);

    // Reset in the middle of a scan aborts it.
    clear_board();
    exp_win = 0; exp_reads.delete(); got_reads.delete(); done_seen = 0;
    @(negedge clk);
    start = 1'b1; player = 2'b01; mv_row = 3'd0; mv_col = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("busy_before_reset", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    #1 check("no_done_after_abort", done_seen, 0);

`ifdef CONNECT4_DRAW_DETECT_EN
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    #1 check("draw_cleared", int'(draw), 0);
    draw_chk = 1'b1;
    for (int n = 1; n <= 42; n++) begin
      exp_draw = (n == 42) ? 1 : 0;
      run_scan(2'b01, 0, 3, 0, 1'b0);
    end
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    #1 check("draw_new_game", int'(draw), 0);
    exp_draw = 0;
    run_scan(2'b01, 0, 3, 0, 1'b0);
    draw_chk = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected one");
    $fatal(1);
  end

endmodule
